// File: rtl/jtsbaskt_objdraw_if.sv
// Draw handshake between object scanner and draw engine, plus the engine's SDRAM fetch port.
interface jtsbaskt_objdraw_if;
  logic        draw;
  logic        busy;
  logic [8:0]  code;
  logic [7:0]  xpos;
  logic [3:0]  pal;
  logic        hflip;
  logic        vflip;
  logic [3:0]  ysub;
  logic        rom_cs;
  logic [13:0] rom_addr;
  logic [31:0] rom_data;
  logic        rom_ok;

  modport master (
    output draw, code, xpos, pal, hflip, vflip, ysub, rom_data, rom_ok,
    input  busy, rom_cs, rom_addr
  );

  modport slave (
    input  draw, code, xpos, pal, hflip, vflip, ysub, rom_data, rom_ok,
    output busy, rom_cs, rom_addr
  );
endinterface

// File: rtl/jtsbaskt_objdraw.sv
// Sprite draw engine: fetches one 16-pixel sprite row as two 8-pixel words, maps through the
// palette PROM into the write half of a double line buffer while the other half plays out.
module jtsbaskt_objdraw #(
  parameter logic [7:0] HOFFSET     = 8'd6,
  parameter bit         BYPASS_PROM = 1'b0,
  parameter bit         HW_MASK     = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pxl_cen,
  input  logic                    cen2,
  input  logic                    LHBL,
  input  logic                    hinit_x,
  input  logic [8:0]              hdump,
  input  logic [3:0]              prog_data,
  input  logic [7:0]              prog_addr,
  input  logic                    prog_en,
  jtsbaskt_objdraw_if.slave       obj,
  output logic [3:0]              pxl
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAW} st_t;

  st_t         st;
  logic [7:0]  xpos_l;
  logic [3:0]  pal_l;
  logic        hflip_l, seg, settled, wbuf;
  logic [2:0]  k;
  logic [31:0] data_l;

  logic [3:0]  prom [256];
  logic [3:0]  lbuf [512];

  logic        hflip_in;
  logic [3:0]  row_in;
  logic [2:0]  nidx;
  logic [3:0]  nib, colour;
  logic [7:0]  wcol;
  logic [8:0]  rd_addr, clr_addr;
  logic        clr_pend;
  logic        unused;

  assign unused   = hdump[8];
  assign hflip_in = obj.hflip & ~HW_MASK;
  assign row_in   = obj.ysub ^ {4{obj.vflip}};
  assign rd_addr  = {~wbuf, hdump[7:0] + HOFFSET};

  always_comb begin
    nidx   = hflip_l ? ~k : k;   // ~k == 7-k for a 3-bit index
    nib    = data_l[{nidx, 2'b00} +: 4];
    colour = BYPASS_PROM ? nib : prom[{pal_l, nib}];
    wcol   = xpos_l + {4'd0, seg, k};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st           <= IDLE;
      obj.busy     <= 1'b0;
      obj.rom_cs   <= 1'b0;
      obj.rom_addr <= '0;
      wbuf         <= 1'b0;
      xpos_l       <= '0;
      pal_l        <= '0;
      hflip_l      <= 1'b0;
      seg          <= 1'b0;
      settled      <= 1'b0;
      k            <= '0;
      data_l       <= '0;
    end else if (cen2) begin
      if (hinit_x) begin
        wbuf       <= ~wbuf;
        st         <= IDLE;
        obj.busy   <= 1'b0;
        obj.rom_cs <= 1'b0;
      end else begin
        case (st)
          IDLE: if (obj.draw) begin
            xpos_l       <= obj.xpos;
            pal_l        <= obj.pal;
            hflip_l      <= hflip_in;
            seg          <= 1'b0;
            settled      <= 1'b0;
            obj.rom_addr <= {obj.code, row_in, hflip_in};
            obj.rom_cs   <= 1'b1;
            obj.busy     <= 1'b1;
            st           <= FETCH;
          end
          FETCH: begin
            // rom_ok is trusted only from the second cen2 after an address change
            settled <= 1'b1;
            if (settled && obj.rom_ok) begin
              data_l <= obj.rom_data;
              k      <= '0;
              st     <= DRAW;
            end
          end
          DRAW: begin
            k <= k + 3'd1;
            if (k == 3'd7) begin
              if (!seg) begin
                seg             <= 1'b1;
                settled         <= 1'b0;
                obj.rom_addr[0] <= ~obj.rom_addr[0];
                st              <= FETCH;
              end else begin
                obj.busy   <= 1'b0;
                obj.rom_cs <= 1'b0;
                st         <= IDLE;
              end
            end
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (prog_en) prom[prog_addr] <= prog_data;
  end

  // Play-out clears each entry right after reading; draw writes target the other half.
  always_ff @(posedge clk) begin
    if (clr_pend) lbuf[clr_addr] <= 4'd0;
    if (cen2 && !hinit_x && st == DRAW && colour != 4'd0) lbuf[{wbuf, wcol}] <= colour;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pxl      <= 4'd0;
      clr_pend <= 1'b0;
      clr_addr <= '0;
    end else begin
      clr_pend <= pxl_cen;
      if (pxl_cen) begin
        pxl      <= LHBL ? lbuf[rd_addr] : 4'd0;
        clr_addr <= rd_addr;
      end
    end
  end

endmodule

// File: tb/tb_jtsbaskt_objdraw.sv
// Randomized bench for the sprite draw engine with a line-level reference model and pxl scoreboard.
module tb_jtsbaskt_objdraw;
  localparam int HOFF = 6;

  logic       clk = 0, rst_n = 1, pxl_cen = 0, cen2 = 0, LHBL = 1, hinit_x = 0;
  logic [8:0] hdump = 0;
  logic [3:0] prog_data = 0;
  logic [7:0] prog_addr = 0;
  logic       prog_en = 0;
  logic [3:0] pxl;

  jtsbaskt_objdraw_if obj();

  jtsbaskt_objdraw dut (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .cen2(cen2), .LHBL(LHBL),
    .hinit_x(hinit_x), .hdump(hdump), .prog_data(prog_data), .prog_addr(prog_addr),
    .prog_en(prog_en), .obj(obj), .pxl(pxl)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  logic [3:0]  prom_m [256];
  logic [3:0]  wr_m [256];
  logic [3:0]  rd_m [256];
  logic [3:0]  got [256];
  bit          rom_hold = 0, rom_fix = 0;
  logic [31:0] rom_fix_val = 0;

  typedef struct { bit chk; logic [3:0] exp; logic [7:0] col; } pe_t;
  pe_t q[$];
  bit  pend = 0;

  function automatic logic [31:0] romv(input logic [13:0] a);
    if (rom_fix) return rom_fix_val;
    return (32'(a) * 32'h9E3779B1) ^ {a[7:0], 24'h0} ^ 32'h1357_9BD0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    cen2 = ~cen2;
  end

  // SDRAM responder: random latency after every address change
  initial begin
    logic [13:0] last;
    bit have;
    int cnt;
    have = 0; cnt = 0; last = 0;
    obj.rom_ok = 0; obj.rom_data = 0;
    forever begin
      @(posedge clk); #2;
      if (!obj.rom_cs || rom_hold) begin
        obj.rom_ok = 0; have = 0;
      end else if (!have || obj.rom_addr !== last) begin
        have = 1; last = obj.rom_addr; obj.rom_ok = 0; cnt = $urandom_range(0, 6);
      end else if (cnt > 0) cnt--;
      else begin
        obj.rom_ok = 1; obj.rom_data = romv(last);
      end
    end
  end

  always @(posedge clk) pend <= pxl_cen;

  always @(negedge clk) begin
    pe_t e;
    if (pend) begin
      if (q.size() == 0) check("pxl_queue_empty", 1, 0);
      else begin
        e = q.pop_front();
        got[e.col] = pxl;
        if (e.chk) check("pxl", {24'd0, e.col, 4'd0, pxl}, {24'd0, e.col, 4'd0, e.exp});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic model_swap();
    rd_m = wr_m;
    foreach (wr_m[i]) wr_m[i] = 4'd0;
  endtask

  task automatic swap();
    @(negedge clk); hinit_x = 1;
    @(negedge clk);
    @(negedge clk); hinit_x = 0;
    model_swap();
  endtask

  task automatic readout(input bit chk, input bit blank);
    for (int h = 0; h < 256; h++) begin
      pe_t e;
      @(negedge clk);
      hdump   = {1'($urandom_range(0, 1)), 8'(h)};
      LHBL    = blank ? ($urandom_range(0, 7) != 0) : 1'b1;
      pxl_cen = 1;
      e.col = 8'(h + HOFF);
      e.exp = LHBL ? rd_m[e.col] : 4'd0;
      e.chk = chk;
      q.push_back(e);
      @(negedge clk); pxl_cen = 0;
    end
    repeat (2) @(negedge clk);
    LHBL = 1;
  endtask

  task automatic sprite(input logic [8:0] code, input logic [7:0] xpos, input logic [3:0] pal,
                        input bit hf, input bit vf, input logic [3:0] ysub, output logic [13:0] first_a);
    logic [13:0] seen[$];
    logic [3:0]  row, nib, c;
    logic [31:0] d;
    int cyc, px;
    @(negedge clk);
    obj.code = code; obj.xpos = xpos; obj.pal = pal;
    obj.hflip = hf; obj.vflip = vf; obj.ysub = ysub; obj.draw = 1;
    cyc = 0;
    while (obj.busy !== 1'b1 && cyc < 8) begin @(negedge clk); cyc++; end
    check("accept", obj.busy, 1);
    obj.draw = 0;
    cyc = 0;
    while (obj.busy === 1'b1 && cyc < 3000) begin
      if (obj.rom_ok && obj.rom_cs && (seen.size() == 0 || seen[$] !== obj.rom_addr))
        seen.push_back(obj.rom_addr);
      @(negedge clk); cyc++;
    end
    check("sprite_done", cyc < 3000, 1);
    check("min_cen2", cyc >= 36, 1);
    check("rom_cs_off", obj.rom_cs, 0);
    row = ysub ^ {4{vf}};
    check("n_fetch", seen.size(), 2);
    first_a = seen.size() > 0 ? seen[0] : 14'h3FFF;
    if (seen.size() == 2) begin
      check("addr0", seen[0], {code, row, hf});
      check("addr1", seen[1], {code, row, ~hf});
    end
    // screen pixel i shows source pixel i, or 15-i when mirrored
    for (int i = 0; i < 16; i++) begin
      px  = hf ? 15 - i : i;
      d   = romv({code, row, 1'(px / 8)});
      nib = d[4 * (px % 8) +: 4];
      c   = prom_m[{pal, nib}];
      if (c != 4'd0) wr_m[8'(int'(xpos) + i)] = c;
    end
  endtask

  initial begin
    logic [13:0] a;
    logic [3:0]  v;
    int cyc;
    obj.draw = 0; obj.code = 0; obj.xpos = 0; obj.pal = 0;
    obj.hflip = 0; obj.vflip = 0; obj.ysub = 0;
    foreach (wr_m[i]) begin wr_m[i] = 0; rd_m[i] = 0; got[i] = 0; end
    #1 rst_n = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", obj.busy, 0);
    check("rst_rom_cs", obj.rom_cs, 0);
    check("rst_rom_addr", obj.rom_addr, 0);
    check("rst_pxl", pxl, 0);
    rst_n = 1;

    for (int i = 0; i < 256; i++) begin
      v = 4'($urandom_range(0, 15));
      if (i == 8'h35) v = 4'hA;
      if (i == 8'h47) v = 4'hC;
      if (i == 8'h40) v = 4'h0;
      @(negedge clk); prog_en = 1; prog_addr = 8'(i); prog_data = v;
      prom_m[i] = v;
    end
    @(negedge clk); prog_en = 0;

    readout(0, 0); swap(); readout(0, 0); swap();

    rom_fix = 1; rom_fix_val = 32'h5555_5555;
    sprite(9'h101, 8'h10, 4'h3, 0, 0, 4'h2, a);
    check("t1_first_addr", a, 14'h2024);
    rom_fix = 0;
    swap(); readout(1, 0);
    check("t1_col10", got[8'h10], 4'hA);
    check("t1_col1f", got[8'h1F], 4'hA);
    check("t1_col20", got[8'h20], 4'h0);
    check("t1_col0f", got[8'h0F], 4'h0);

    sprite(9'h000, 8'h80, 4'($urandom_range(0, 15)), 1, 1, 4'h0, a);
    check("t2_first_addr", a, 14'h01F);
    sprite(9'($urandom_range(0, 511)), 8'hF8, 4'($urandom_range(0, 15)), 0, 0, 4'($urandom_range(0, 15)), a);
    swap(); readout(1, 1);

    rom_fix = 1; rom_fix_val = 32'h5555_5555;
    sprite(9'h055, 8'h40, 4'h3, 0, 0, 4'h1, a);
    rom_fix_val = 32'h0000_0007;
    sprite(9'h066, 8'h44, 4'h4, 0, 0, 4'h1, a);
    rom_fix = 0;
    swap(); readout(1, 0);
    check("t5_overlap_kept", got[8'h45], 4'hA);
    check("t5_col44", got[8'h44], 4'hC);
    check("t5_col4c", got[8'h4C], 4'hC);
    check("t5_col53", got[8'h53], 4'h0);

    repeat (6) begin
      repeat ($urandom_range(1, 5))
        sprite(9'($urandom_range(0, 511)), 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a);
      swap(); readout(1, 1);
    end

    rom_hold = 1;
    @(negedge clk); obj.code = 9'h1AB; obj.xpos = 8'h30; obj.draw = 1;
    cyc = 0;
    while (obj.busy !== 1'b1 && cyc < 8) begin @(negedge clk); cyc++; end
    obj.draw = 0;
    repeat (40) @(negedge clk);
    check("stall_busy", obj.busy, 1);
    check("stall_rom_cs", obj.rom_cs, 1);
    @(negedge clk); hinit_x = 1; obj.draw = 1;
    @(negedge clk);
    @(negedge clk); hinit_x = 0; obj.draw = 0;
    model_swap();
    check("abort_busy", obj.busy, 0);
    check("abort_rom_cs", obj.rom_cs, 0);
    @(negedge clk);
    check("draw_with_hinit_ignored", obj.busy, 0);
    rom_hold = 0;
    readout(1, 1);
    swap(); readout(1, 0);

    rom_hold = 1;
    @(negedge clk); obj.draw = 1;
    cyc = 0;
    while (obj.busy !== 1'b1 && cyc < 8) begin @(negedge clk); cyc++; end
    obj.draw = 0;
    check("fetch_busy", obj.busy, 1);
    repeat (5) @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("async_rst_busy", obj.busy, 0);
    check("async_rst_rom_cs", obj.rom_cs, 0);
    check("async_rst_pxl", pxl, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
